// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  localparam int MAX_LOCK_DEF = 16;

  // Counter must hold 0..max_lock inclusive.
  function automatic int lk_cnt_w(input int max_lock);
    return $clog2(max_lock + 1);
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the two masters, the arbiter and the single-port memory.
// Handshake: reqN is the valid and gntN the (combinational) ready; an access is
// issued in a cycle with reqN && gntN, and lockN/addrN/weN/wdataN stay stable
// until then. rvalidN is a one-cycle strobe with no backpressure.
interface mem_arb_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          req0, req1;
  logic          lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic          we0, we1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;
  logic          busy;

  modport slave (
    input  req0, req1, lock0, lock1, addr0, addr1, we0, we1, wdata0, wdata1, mem_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_data, mem_wren, busy
  );

  modport master (
    output req0, req1, lock0, lock1, addr0, addr1, we0, we1, wdata0, wdata1, mem_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_data, mem_wren, busy
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for mem_arbiter, including lock bookkeeping flags.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise master 0 wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_DEF,
  parameter int CW       = lk_cnt_w(MAX_LOCK)
) (
  input  logic [1:0]    req,
  input  logic [1:0]    lock,
  input  logic          lk_v,
  input  master_t       lk_own,
  input  logic [CW-1:0] lk_cnt,
  input  master_t       last,
  output logic [1:0]    gnt,
  output master_t       win,
  output logic          set_lock,
  output logic          clr_lock,
  output logic          inc_cnt
);

  logic    locked;
  master_t other;

  assign locked = lk_v && lock[lk_own];
  assign other  = master_t'(~lk_own);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    gnt      = 2'b00;
    win      = M0;
    set_lock = 1'b0;
    clr_lock = 1'b0;
    inc_cnt  = 1'b0;
    if (locked) begin
      // Owner has used its budget and the other side is waiting: hand over.
      if (lk_cnt == CW'(MAX_LOCK) && req[other]) begin
        win      = other;
        gnt[other] = 1'b1;
        clr_lock = 1'b1;
      end else if (req[lk_own]) begin
        win        = lk_own;
        gnt[lk_own] = 1'b1;
        inc_cnt    = 1'b1;
      end
    end else begin
      clr_lock = 1'b1;
      if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = master_t'(~last);
`else
        win = M0;
`endif
      end else if (req[1]) begin
        win = M1;
      end
      if (|req) begin
        gnt[win] = 1'b1;
        if (lock[win]) begin
          set_lock = 1'b1;
          clr_lock = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port synchronous memory with bounded lock.
// ARB_ROUND_ROBIN_EN enables round-robin tie-breaking (default: master 0 wins ties).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_DEF,
  parameter int CW       = lk_cnt_w(MAX_LOCK)
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arb_if.slave      bus,
  output master_t       dbg_last,
  output logic          dbg_lk_v,
  output master_t       dbg_lk_own,
  output logic [CW-1:0] dbg_lk_cnt
);

  master_t       last, lk_own, win;
  logic          lk_v, rv0, rv1;
  logic [CW-1:0] lk_cnt;
  logic [1:0]    gnt;
  logic          set_lock, clr_lock, inc_cnt;

  mem_arb_pick #(.MAX_LOCK(MAX_LOCK), .CW(CW)) u_pick (
    .req      ({bus.req1, bus.req0}),
    .lock     ({bus.lock1, bus.lock0}),
    .lk_v     (lk_v),
    .lk_own   (lk_own),
    .lk_cnt   (lk_cnt),
    .last     (last),
    .gnt      (gnt),
    .win      (win),
    .set_lock (set_lock),
    .clr_lock (clr_lock),
    .inc_cnt  (inc_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last   <= M1;
      lk_v   <= 1'b0;
      lk_own <= M0;
      lk_cnt <= '0;
      rv0    <= 1'b0;
      rv1    <= 1'b0;
    end else begin
      rv0 <= gnt[0] & ~bus.we0;
      rv1 <= gnt[1] & ~bus.we1;
      if (|gnt) last <= win;
      if (set_lock) begin
        lk_v   <= 1'b1;
        lk_own <= win;
        lk_cnt <= CW'(1);
      end else if (clr_lock) begin
        lk_v   <= 1'b0;
        lk_cnt <= '0;
      end else if (inc_cnt && lk_cnt != CW'(MAX_LOCK)) begin
        lk_cnt <= lk_cnt + CW'(1);
      end
    end
  end

  assign bus.gnt0     = gnt[0];
  assign bus.gnt1     = gnt[1];
  assign bus.rvalid0  = rv0;
  assign bus.rvalid1  = rv1;
  assign bus.rdata0   = bus.mem_q;
  assign bus.rdata1   = bus.mem_q;
  assign bus.mem_addr = gnt[0] ? bus.addr0 : (gnt[1] ? bus.addr1 : '0);
  assign bus.mem_data = gnt[0] ? bus.wdata0 : (gnt[1] ? bus.wdata1 : '0);
  assign bus.mem_wren = (gnt[0] & bus.we0) | (gnt[1] & bus.we1);
  assign bus.busy     = lk_v;

  assign dbg_last   = last;
  assign dbg_lk_v   = lk_v;
  assign dbg_lk_own = lk_own;
  assign dbg_lk_cnt = lk_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, async-reset sequence, and random
// traffic against a rule-level reference model with a read-data expected queue.
module tb_mem_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int MAXL = 4;
  localparam int CW   = $clog2(MAXL + 1);
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk, rst_n;
  logic          dbg_last, dbg_lk_v, dbg_lk_own;
  logic [CW-1:0] dbg_lk_cnt;

  mem_arb_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.MAX_LOCK(MAXL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .dbg_last   (dbg_last),
    .dbg_lk_v   (dbg_lk_v),
    .dbg_lk_own (dbg_lk_own),
    .dbg_lk_cnt (dbg_lk_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory environment ----------------
  logic [DW-1:0] ram  [256];
  logic [DW-1:0] mram [256];

  initial begin : mem_env
    for (int i = 0; i < 256; i++) begin
      ram[i]  = 16'($urandom);
      mram[i] = ram[i];
    end
    ram[5]    = 16'h1234;
    mram[5]   = 16'h1234;
    bus.mem_q = '0;
    forever begin
      @(posedge clk);
      bus.mem_q = ram[bus.mem_addr];
      if (bus.mem_wren) ram[bus.mem_addr] = bus.mem_data;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int            n_cmp, n_err;
  logic [DW-1:0] exp_q[$];
  int            m_last, m_own, m_cnt;
  bit            m_lk_v;
  bit            m_rv[2];
  logic [AW-1:0] cur_a[2];
  logic [DW-1:0] cur_d[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_last = 1; m_own = 0; m_cnt = 0; m_lk_v = 1'b0;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    exp_q.delete();
  endfunction

  // Which master gets the memory this cycle (-1 = none), from the lock/tie rules.
  function automatic int model_pick(input logic [1:0] req, input logic [1:0] lock);
    if (m_lk_v && lock[m_own]) begin
      if (m_cnt == MAXL && req[1 - m_own]) return 1 - m_own;
      return req[m_own] ? m_own : -1;
    end
    if (req == 2'b11) return RR ? 1 - m_last : 0;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  function automatic void model_step(input int g, input logic [1:0] lock, input logic [1:0] we);
    bit locked = m_lk_v && lock[m_own];
    m_rv[0] = (g == 0) && !we[0];
    m_rv[1] = (g == 1) && !we[1];
    if (g >= 0) begin
      m_last = g;
      if (we[g]) mram[cur_a[g]] = cur_d[g];
      else exp_q.push_back(mram[cur_a[g]]);
    end
    if (locked) begin
      if (g == 1 - m_own) begin
        m_lk_v = 1'b0; m_cnt = 0;
      end else if (g == m_own && m_cnt < MAXL) begin
        m_cnt++;
      end
    end else if (g >= 0 && lock[g]) begin
      m_lk_v = 1'b1; m_own = g; m_cnt = 1;
    end else begin
      m_lk_v = 1'b0; m_cnt = 0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0; bus.lock1 = 1'b0;
    bus.we0 = 1'b0; bus.we1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  // One clock cycle: drive at negedge, check everything against the model, advance it.
  task automatic drive(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, output int g);
    logic [1:0] xg;
    @(negedge clk);
    bus.req0 = req[0]; bus.req1 = req[1]; bus.lock0 = lock[0]; bus.lock1 = lock[1];
    bus.we0 = we[0]; bus.we1 = we[1]; bus.addr0 = a0; bus.addr1 = a1;
    bus.wdata0 = d0; bus.wdata1 = d1;
    cur_a[0] = a0; cur_a[1] = a1; cur_d[0] = d0; cur_d[1] = d1;
    #1;
    chk("rvalid0", bus.rvalid0, m_rv[0]);
    chk("rvalid1", bus.rvalid1, m_rv[1]);
    if (m_rv[0]) chk("rdata0", bus.rdata0, exp_q.size() > 0 ? exp_q.pop_front() : 'x);
    if (m_rv[1]) chk("rdata1", bus.rdata1, exp_q.size() > 0 ? exp_q.pop_front() : 'x);
    chk("busy", bus.busy, m_lk_v);
    chk("lk_v", dbg_lk_v, m_lk_v);
    chk("last", dbg_last, 32'(m_last));
    chk("lk_cnt", dbg_lk_cnt, 32'(m_cnt));
    if (m_lk_v) chk("lk_own", dbg_lk_own, 32'(m_own));
    g  = model_pick(req, lock);
    xg = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    chk("gnt", {bus.gnt1, bus.gnt0}, xg);
    chk("mem_wren", bus.mem_wren, (g >= 0) ? we[g] : 1'b0);
    chk("mem_addr", bus.mem_addr, (g >= 0) ? 32'(cur_a[g]) : 32'd0);
    chk("mem_data", bus.mem_data, (g >= 0) ? 32'(cur_d[g]) : 32'd0);
    model_step(g, lock, we);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mem", {bus.mem_wren, bus.mem_addr, bus.mem_data}, '0);
    chk("rst_last", dbg_last, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]    req, lock, we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    xg, xr;
    logic          xb;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d1, input logic [1:0] xg,
                              input logic [1:0] xr, input logic xb);
    vec_t v;
    v.req = req; v.lock = lock; v.we = we; v.a0 = a0; v.a1 = a1;
    v.d0 = 16'h0; v.d1 = d1; v.xg = xg; v.xr = xr; v.xb = xb;
    return v;
  endfunction

  localparam int NV = 19;
  vec_t tbl[NV];

  initial begin
    int            g;
    bit            p[2];
    logic [1:0]    rl, rw;
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rd[2];

    rst_n = 1'b0;
    idle_inputs();
    n_cmp = 0;
    n_err = 0;
    model_reset();

    //            req    lock   we     a0     a1     d1        gnt                 rvalid              busy
    tbl[0]  = mk(2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 16'h0000, 2'b01,              2'b00,              1'b0);
    tbl[1]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 2'b00,              2'b01,              1'b0);
    tbl[2]  = mk(2'b10, 2'b00, 2'b10, 8'h00, 8'h20, 16'hBEEF, 2'b10,              2'b00,              1'b0);
    tbl[3]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 2'b00,              2'b00,              1'b0);
    tbl[4]  = mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 16'h0000, 2'b01,              2'b00,              1'b0);
    tbl[5]  = mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 16'h0000, RR ? 2'b10 : 2'b01, 2'b01,              1'b0);
    tbl[6]  = mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 16'h0000, 2'b01,              RR ? 2'b10 : 2'b01, 1'b0);
    tbl[7]  = mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 16'h0000, RR ? 2'b10 : 2'b01, 2'b01,              1'b0);
    tbl[8]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 2'b00,              RR ? 2'b10 : 2'b01, 1'b0);
    tbl[9]  = mk(2'b11, 2'b01, 2'b00, 8'h30, 8'h31, 16'h0000, 2'b01,              2'b00,              1'b0);
    tbl[10] = mk(2'b11, 2'b01, 2'b00, 8'h30, 8'h31, 16'h0000, 2'b01,              2'b01,              1'b1);
    tbl[11] = mk(2'b11, 2'b01, 2'b00, 8'h30, 8'h31, 16'h0000, 2'b01,              2'b01,              1'b1);
    tbl[12] = mk(2'b11, 2'b01, 2'b00, 8'h30, 8'h31, 16'h0000, 2'b01,              2'b01,              1'b1);
    tbl[13] = mk(2'b11, 2'b01, 2'b00, 8'h30, 8'h31, 16'h0000, 2'b10,              2'b01,              1'b1);
    tbl[14] = mk(2'b11, 2'b01, 2'b00, 8'h32, 8'h31, 16'h0000, 2'b01,              2'b10,              1'b0);
    tbl[15] = mk(2'b10, 2'b01, 2'b00, 8'h00, 8'h33, 16'h0000, 2'b00,              2'b01,              1'b1);
    tbl[16] = mk(2'b10, 2'b01, 2'b00, 8'h00, 8'h33, 16'h0000, 2'b00,              2'b00,              1'b1);
    tbl[17] = mk(2'b10, 2'b00, 2'b00, 8'h00, 8'h33, 16'h0000, 2'b10,              2'b00,              1'b1);
    tbl[18] = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 2'b00,              2'b10,              1'b0);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, g);
      chk($sformatf("tbl%0d_gnt", i), {bus.gnt1, bus.gnt0}, tbl[i].xg);
      chk($sformatf("tbl%0d_rvalid", i), {bus.rvalid1, bus.rvalid0}, tbl[i].xr);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].xb);
      if (i == 1) chk("tbl1_rdata0", bus.rdata0, 16'h1234);
      if (i == 2) chk("tbl2_write", {bus.mem_wren, bus.mem_addr, bus.mem_data}, {1'b1, 8'h20, 16'hBEEF});
    end

    // Asynchronous reset while a locked read is in flight.
    drive(2'b01, 2'b01, 2'b00, 8'h40, 8'h00, 16'h0, 16'h0, g);
    drive(2'b01, 2'b01, 2'b00, 8'h41, 8'h00, 16'h0, 16'h0, g);
    chk("arst_busy_before", bus.busy, 1'b1);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_rvalid0", bus.rvalid0, 1'b0);
    chk("arst_last", dbg_last, 1'b1);
    #1;
    rst_n = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, g);
    chk("arst_rvalid0_after", bus.rvalid0, 1'b0);

    // Random traffic: requests held until granted, sticky lock inputs.
    do_reset();
    p[0] = 1'b0; p[1] = 1'b0; rl = 2'b00; rw = 2'b00;
    ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p[m] && $urandom_range(0, 99) < 55) begin
          p[m]  = 1'b1;
          ra[m] = AW'($urandom_range(0, 255));
          rw[m] = 1'($urandom_range(0, 1));
          rd[m] = DW'($urandom);
        end
        if ($urandom_range(0, 9) == 0) rl[m] = ~rl[m];
      end
      drive({p[1], p[0]}, rl, rw, ra[0], ra[1], rd[0], rd[1], g);
      if (g >= 0) p[g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single-port synchronous instruction/data memory (8-bit address, 16-bit data, 1-cycle read latency) between the processor bus and a second master, such as a memory loader or DMA engine. It sits between the masters' request/address/data lines and the memory's address, data, wren and q pins. It grants at most one access per cycle and returns read data with a registered valid strobe. It also supports bounded exclusive ownership (lock) for read-modify-write sequences.

## Interface
- AW, 8: memory address width.
- DW, 16: data width.
- MAX_LOCK, 16: maximum locked grants before forced release when the other master is waiting; ≥1.

- Clock  in  1  single clock; all state on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; addr/we/wdata held stable until gnt.
- lock0 / lock1  in  1  request exclusive ownership after the next grant.
- addr0 / addr1  in  AW  word address.
- we0 / we1  in  1  1 = write, 0 = read.
- wdata0 / wdata1  in  DW  write data.
- gnt0 / gnt1  out  1  combinational; access issued to memory this cycle.
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle.
- rdata0 / rdata1  out  DW  = mem_q, qualified by rvalid.
- mem_addr  out  AW  granted master's addr, 0 when idle.
- mem_data  out  DW  granted master's wdata, 0 when idle.
- mem_wren  out  1  granted & we.
- mem_q  in  DW  memory read data, valid the cycle after address presented.
- busy  out  1  lock currently held (registered).

## Operation
- State registers: last (last granted master), lk_v (lock valid), lk_own (lock owner), lk_cnt (width clog2(MAX_LOCK+1)), rv0/rv1.
- Lock mode applies in a cycle iff lk_v=1 and lock input of lk_own is 1. Otherwise the arbiter is unlocked and lk_v clears at the edge.
- Locked mode:
  - Only lk_own may be granted; the other master waits even if the owner is idle.
  - Each owner grant increments lk_cnt, saturating at MAX_LOCK.
  - Forced release: if lk_cnt == MAX_LOCK and the other master requests, grant the other master, clear lk_v, and zero lk_cnt.
- Unlocked mode:
  - Single requester is granted.
  - Both requesting: arbitration per Configuration.
  - A grant with the granted master's lock=1 sets lk_v, sets lk_own to that master, and sets lk_cnt=1.
- Each grant updates last.
- A read grant in cycle N sets rvX=1 for cycle N+1 only. Writes never produce rvalid.
- gnt0 and gnt1 are never both 1.

## Timing
- Reset values: all outputs 0, lk_v=0, lk_cnt=0, rv=0, last=1 (master 0 wins the first tie).
- Grant latency: 0 cycles (same cycle as req when eligible).
- Read latency: rvalid exactly 1 cycle after gnt.
- Throughput: one access per cycle, back-to-back, alternating allowed.
- Reset asserted mid-operation: pending rvalid is dropped and the lock is cleared immediately (asynchronous).
- Owner drops lock in the same cycle the other master requests: unlocked arbitration applies that cycle.
- Locked owner requests while the other master waits and lk_cnt < MAX_LOCK: owner is granted.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, grant the master not equal to last.
- ARB_ROUND_ROBIN_EN undefined: on a tie, master 0 always wins. last is still tracked but unused for ties. Forced lock release still applies.

## Structure
- Package mem_arb_pkg: master index type (M0=0, M1=1), lock-counter width function, MAX_LOCK default constant.
- One sub-module, mem_arb_pick: combinational winner selection from req, lock state, lk_cnt and last. It outputs the grant vector plus set-lock/clear-lock flags.
- Top module holds the registers and memory-side muxing.

## Test plan
- Reset, then req0=1 we0=0 addr0=8'h05 with mem_q=16'h1234 next cycle -> gnt0=1 in cycle 0; rvalid0=1 with rdata0=16'h1234 in cycle 1; rvalid1 stays 0.
- Both request reads continuously with round-robin enabled -> grants alternate 0,1,0,1. With the macro undefined -> gnt0 every cycle, gnt1 never.
- req1=1 we1=1 addr1=8'h20 wdata1=16'hBEEF -> mem_wren=1, mem_addr=8'h20, mem_data=16'hBEEF in the same cycle; no rvalid1.
- lock0=1 with req0 held, req1=1 throughout, MAX_LOCK=4 -> gnt0 for 4 cycles, gnt1 in cycle 5, busy falls after cycle 5.
- lock0 held but req0=0 while req1=1 -> no grants while lk_v; dropping lock0 -> gnt1 that same cycle.
- Read granted, then Resetn pulsed low before the next edge -> rvalid0 stays 0, busy=0, last=1.
